// File: rtl/fifo_arb_pkg.sv
// Shared types and sizing helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

  localparam int WR_CNT_W = 16;

  function automatic int ptr_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/fifo_arb_rr_pick.sv
// Combinational rotating-priority picker: first set request at or after ptr_i, wrapping.
module fifo_arb_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic               vld_o,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [PTR_W-1:0]   idx_o
);

  int               sum;
  logic [PTR_W-1:0] pos;

  always_comb begin
    vld_o = 1'b0;
    gnt_o = '0;
    idx_o = '0;
    sum   = 0;
    pos   = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      sum = int'(ptr_i) + off;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      pos = PTR_W'(sum);
      if (!vld_o && req_i[pos]) begin
        vld_o      = 1'b1;
        gnt_o[pos] = 1'b1;
        idx_o      = pos;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for a FIFO write port; zero-cycle grant, stalls while i_full.
// FIFO_ARB_STATS_EN adds per-requester 16-bit accepted-beat counters on o_wr_cnt.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int SIZE_DATA = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [NUM_REQ-1:0]             i_req,
  input  logic [NUM_REQ*SIZE_DATA-1:0]   i_data,
  output logic [NUM_REQ-1:0]             o_gnt,
  input  logic                           i_full,
  output logic                           o_wr_en,
`ifdef FIFO_ARB_STATS_EN
  output logic [SIZE_DATA-1:0]           o_data_wr,
  output logic [NUM_REQ*WR_CNT_W-1:0]    o_wr_cnt
`else
  output logic [SIZE_DATA-1:0]           o_data_wr
`endif
);

  localparam int PTR_W = ptr_w(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  localparam arb_state_e POST_ARB = (MAX_BURST > 1) ? ARB_BURST : ARB_IDLE;

  arb_state_e       state_q;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] owner_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic               pick_vld;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [PTR_W-1:0]   pick_idx;
  logic               lock_vld;
  logic               accept;
  logic [PTR_W-1:0]   win_idx;
  logic [SIZE_DATA-1:0] data_sel;

  fifo_arb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req_i (i_req),
    .ptr_i (ptr_q),
    .vld_o (pick_vld),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );

  assign lock_vld = (state_q == ARB_BURST) && i_req[owner_q];
  assign win_idx  = lock_vld ? owner_q : pick_idx;
  // Reset gates the outputs so nothing is written while i_rst is held.
  assign accept   = (lock_vld || pick_vld) && !i_full && !i_rst;
  assign ptr_d    = (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx + PTR_W'(1);
  assign cnt_d    = cnt_q + CNT_W'(1);

  always_comb begin
    data_sel = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_idx == PTR_W'(k)) data_sel = i_data[k*SIZE_DATA +: SIZE_DATA];
    end
  end

  assign o_wr_en   = accept;
  assign o_gnt     = !accept ? '0 : (lock_vld ? (NUM_REQ'(1) << owner_q) : pick_gnt);
  assign o_data_wr = accept ? data_sel : '0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
    end else if (accept) begin
      if (lock_vld) begin
        cnt_q <= cnt_d;
        if (cnt_d == CNT_MAX) state_q <= ARB_IDLE;
      end else begin
        owner_q <= pick_idx;
        cnt_q   <= CNT_W'(1);
        ptr_q   <= ptr_d;
        state_q <= POST_ARB;
      end
    end else if (!i_full) begin
      state_q <= ARB_IDLE;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [NUM_REQ*WR_CNT_W-1:0] wr_cnt_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_cnt_q <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (o_gnt[k]) wr_cnt_q[k*WR_CNT_W +: WR_CNT_W] <= wr_cnt_q[k*WR_CNT_W +: WR_CNT_W] + WR_CNT_W'(1);
      end
    end
  end

  assign o_wr_cnt = wr_cnt_q;
`endif

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the write side of one FIFO between NUM_REQ requesters in a single clock domain. Requests are granted with zero-cycle latency and throttled by the FIFO full flag. A granted requester may keep the port for a burst of up to MAX_BURST consecutive beats. The block sits directly in front of the FIFO write port (i_wr_en / i_data_wr / o_full) and is the only driver of that port.

## Interface
- NUM_REQ, 4, number of requesters (2..16)
- SIZE_DATA, 8, data width, matches FIFO SIZE_DATA
- MAX_BURST, 4, max consecutive beats per grant (1 = pure per-beat round-robin)
- i_clk  input  1  single clock, write clock of the FIFO
- i_rst  input  1  asynchronous, active-high reset
- i_req  input  NUM_REQ  per-requester write request, held with data until granted
- i_data  input  NUM_REQ*SIZE_DATA  packed request data, requester k at bits [k*SIZE_DATA +: SIZE_DATA]
- o_gnt  output  NUM_REQ  one-hot; beat of requester k accepted at this clock edge
- i_full  input  1  FIFO full flag
- o_wr_en  output  1  FIFO write enable
- o_data_wr  output  SIZE_DATA  FIFO write data (selected requester)
- o_wr_cnt  output  NUM_REQ*16  per-requester accepted-beat counters (only with FIFO_ARB_STATS_EN)

## Operation
- State: rr pointer ptr (clog2(NUM_REQ) bits), owner index, burst count cnt (clog2(MAX_BURST+1) bits), FSM {ARB_IDLE, ARB_BURST}.
- Lock valid = state ARB_BURST and i_req[owner] = 1.
- If lock valid, the winner is owner. Otherwise the winner is the first k with i_req[k] = 1, searching ptr, ptr+1, … modulo NUM_REQ.
- Beat accepted when a winner exists and i_full = 0. On acceptance: o_gnt[winner] = 1, o_wr_en = 1, o_data_wr = i_data[winner].
- On acceptance from arbitration (no valid lock):
  - owner <= winner, cnt <= 1, ptr <= winner+1 mod NUM_REQ.
  - Next state is ARB_BURST if MAX_BURST > 1, else ARB_IDLE.
- On acceptance under a valid lock:
  - cnt <= cnt+1.
  - If cnt+1 == MAX_BURST, next state is ARB_IDLE.
- In ARB_BURST with the owner request dropped: arbitration happens in the same cycle (no bubble), and a new owner may be granted. The old owner is never re-granted before ptr passes it.
- i_full = 1: o_gnt = 0, o_wr_en = 0; FSM, ptr, owner and cnt hold. The burst resumes when full clears.
- No request and not full: outputs 0, FSM returns to ARB_IDLE, ptr holds.
- Requesters must hold i_req/i_data stable until o_gnt is sampled high. Deasserting i_req before grant is legal (request withdrawn).

## Timing
- o_gnt, o_wr_en, o_data_wr are combinational from state, i_req, i_data, i_full: zero-cycle latency. State updates on posedge i_clk.
- i_full feeds outputs combinationally; the FIFO's full flag must be valid early in the write-clock cycle.
- Reset (i_rst asserted, immediate): state ARB_IDLE, ptr = 0, owner = 0, cnt = 0, o_wr_cnt = 0. The combinational outputs then follow the idle rules. Reset mid-burst abandons the burst; the next grant after release goes to the lowest requesting index.
- Sustained throughput: one beat per cycle while any request is present and i_full = 0.

## Configuration
- FIFO_ARB_STATS_EN defined:
  - o_wr_cnt is present.
  - Each 16-bit counter increments on every accepted beat of its requester and wraps 0xFFFF -> 0.
  - Counters are cleared by i_rst.
- Not defined: o_wr_cnt port and counters are absent. Arbitration behaviour is identical.

## Structure
- Package fifo_arb_pkg holds:
  - the FSM state enum (ARB_IDLE, ARB_BURST);
  - the counter width constant (WR_CNT_W = 16);
  - a helper function computing pointer width from NUM_REQ.
- One sub-module, fifo_arb_rr_pick: purely combinational rotating-priority picker. Inputs are the request vector and ptr; outputs are valid, one-hot winner and winner index. The FSM, counters and data mux stay in fifo_wr_arbiter.

## Test plan
- Reset: assert i_rst with i_req = 4'b1111 -> o_gnt = 0, o_wr_en = 0 while reset is held. The first grant after release is requester 0, and it keeps the grant for 4 beats.
- Round-robin, MAX_BURST = 1, i_req = 4'b1111 held -> grants cycle 0,1,2,3,0,… one per cycle; o_data_wr follows the selected slice.
- Burst lock, MAX_BURST = 4, i_req = 4'b0011 -> four beats to requester 0, then four to requester 1, alternating.
- Owner drops mid-burst: requester 2 drops i_req after 2 beats, requester 3 requesting -> requester 3 is granted in that same cycle with no idle cycle.
- Full stall: raise i_full for 3 cycles during beat 2 of a burst -> o_wr_en = 0 for 3 cycles, then beats 3 and 4 go to the same owner.
- Stats (FIFO_ARB_STATS_EN): 10 beats accepted for requester 1 -> o_wr_cnt slice 1 = 10, others unchanged. Preload the counter to 0xFFFF via stimulus, accept one more beat -> counter wraps to 0.
